// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   state_t        : sequencer FSM states
//   ALU_CTRL_*     : function select codes of the shared bit-slice ALU
//   OP_MULTU/DIVU  : operation select carried on the 'op' request input
package alu_muldiv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] ALU_CTRL_AND    = 2'b00;
    localparam logic [1:0] ALU_CTRL_OR     = 2'b01;
    localparam logic [1:0] ALU_CTRL_ADDSUB = 2'b10;
    localparam logic [1:0] ALU_CTRL_SLT    = 2'b11;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/alu_muldiv_seq_step_mux.sv
// muldiv_step_mux: combinational per-iteration datapath of the sequencer.
// Selects what the shared ALU sees and computes the next {hi,lo} from the
// ALU's answer.
//   active       in  : 1 while the sequencer is iterating (CALC)
//   op           in  : OP_MULTU / OP_DIVU of the running operation
//   hi, lo       in  : current HI/LO registers
//   mcand        in  : multiplicand (MULTU) or divisor (DIVU)
//   alu_result   in  : ALU sum
//   alu_cout     in  : ALU carry out (subtract: 1 = no borrow)
//   alu_a, alu_b out : ALU operands, zero when not active
//   alu_bin      out : 1 = subtract
//   hi_nxt       out : HI value to load this cycle
//   lo_nxt       out : LO value to load this cycle
module muldiv_step_mux
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             active,
    input  logic             op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_bin,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH-1:0] sh;
    logic             take;

    // Partial remainder shifted left with the next dividend bit.
    assign sh = {hi[WIDTH-2:0], lo[WIDTH-1]};
    // hi[MSB] is dropped by the shift, so sh really exceeds the divisor.
    assign take = alu_cout | hi[WIDTH-1];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        alu_a   = '0;
        alu_b   = '0;
        alu_bin = 1'b0;
        hi_nxt  = hi;
        lo_nxt  = lo;
        if (active) begin
            if (op == OP_MULTU) begin
                alu_a            = hi;
                alu_b            = lo[0] ? mcand : '0;
                {hi_nxt, lo_nxt} = {alu_cout, alu_result, lo[WIDTH-1:1]};
            end else begin
                alu_a   = sh;
                alu_b   = mcand;
                alu_bin = 1'b1;
                hi_nxt  = take ? alu_result : sh;
                lo_nxt  = {lo[WIDTH-2:0], take};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned MULTU (shift-add) / DIVU (restoring)
// sequencer driving the shared EX-stage ALU, one add/subtract per cycle.
//   clk, rst_n            : clock, async active-low reset
//   start, op, opa, opb   : request, sampled only in IDLE
//   alu_a/b/ctrl/bin      : ALU drive, valid during CALC, zero otherwise
//   alu_result, alu_cout  : ALU answer
//   busy                  : high in CALC (pipeline stall)
//   done                  : one-cycle pulse in DONE
//   hi, lo                : product {hi,lo}, or remainder/quotient
//   div_zero              : last DIVU had a zero divisor
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    output logic             alu_bin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             op_q;
    logic             div_zero_q;
    logic             accept, zero_div;

    assign accept   = (state_q == IDLE) && start;
    assign zero_div = (op == OP_DIVU) && (opb == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = zero_div ? DONE : CALC;
            CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: state is updated with <= so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            op_q       <= OP_MULTU;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            cnt_q      <= '0;
            mcand_q    <= (op == OP_MULTU) ? opa : opb;
            op_q       <= op;
            div_zero_q <= zero_div;
            if (op == OP_MULTU) begin
                hi_q <= '0;
                lo_q <= opb;
            end else if (zero_div) begin
                hi_q <= opa;
                lo_q <= '1;
            end else begin
                hi_q <= '0;
                lo_q <= opa;
            end
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
        end
    end

    muldiv_step_mux #(.WIDTH(WIDTH)) u_step (
        .active     (state_q == CALC),
        .op         (op_q),
        .hi         (hi_q),
        .lo         (lo_q),
        .mcand      (mcand_q),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_bin    (alu_bin),
        .hi_nxt     (hi_nxt),
        .lo_nxt     (lo_nxt)
    );

    assign busy     = (state_q == CALC);
    assign done     = (state_q == DONE);
    assign alu_ctrl = busy ? ALU_CTRL_ADDSUB : ALU_CTRL_AND;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural WIDTH-bit ALU on the
// alu_* ports. Inputs are driven and outputs sampled on the falling edge.
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] opa = '0, opb = '0;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [1:0]   alu_ctrl;
    logic         alu_bin, alu_cout;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_bin    (alu_bin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_zero   (div_zero)
    );

    // Shared ALU: AND / OR / ADD-SUB / SLT with carry out of the MSB.
    logic [W:0] sum;
    always_comb begin
        sum = {1'b0, alu_a} + {1'b0, alu_b ^ {W{alu_bin}}} + {{W{1'b0}}, alu_bin};
        alu_cout = sum[W];
        case (alu_ctrl)
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a | alu_b;
            2'b10:   alu_result = sum[W-1:0];
            default: alu_result = {{(W-1){1'b0}}, ~sum[W]};
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns the number of rising edges from the
    // accepting edge (counted as 1) to the first sample with done high,
    // the number of busy samples, and ALU control seen in the first CALC cycle.
    // If repulse_at > 0, a second start with other operands is driven then.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int repulse_at,
                          output int lat, output int busy_n, output logic [2:0] ctl);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_n = 0;
        ctl = {alu_ctrl, alu_bin};
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            if (lat == repulse_at) begin
                start = 1'b1; op = ~o; opa = 32'h0000_0003; opb = 32'h0000_0005;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (lat >= 100) check("done_timeout", 64'(lat), 64'd33);
    endtask

    int         lat, busy_n;
    logic [2:0] ctl;

    initial begin
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_alu",  {alu_a, alu_b}, 64'd0);
        check("rst_ctrl", {61'd0, alu_ctrl, alu_bin}, 64'd0);
        rst_n = 1'b1;

        // MULTU 6 x 7
        run_op(1'b0, 32'd6, 32'd7, 0, lat, busy_n, ctl);
        check("mul6x7_lat",  64'(lat), 64'd33);
        check("mul6x7_busy", 64'(busy_n), 64'd32);
        check("mul6x7_ctl",  64'(ctl), 64'b100);
        check("mul6x7_hilo", {hi, lo}, 64'h0000_0000_0000_002A);
        check("mul6x7_dz",   64'(div_zero), 64'd0);
        @(negedge clk);
        check("mul6x7_idle", 64'(done), 64'd0);
        @(negedge clk);
        check("mul6x7_hold", {hi, lo}, 64'h0000_0000_0000_002A);

        // MULTU max x max
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, busy_n, ctl);
        check("mulmax_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // DIVU 100 / 7
        run_op(1'b1, 32'd100, 32'd7, 0, lat, busy_n, ctl);
        check("div100_ctl",  64'(ctl), 64'b101);
        check("div100_lat",  64'(lat), 64'd33);
        check("div100_hilo", {hi, lo}, {32'd2, 32'd14});

        // DIVU 0x80000000 / 0xFFFFFFFF
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, busy_n, ctl);
        check("divmsb_hilo", {hi, lo}, {32'h8000_0000, 32'h0});

        // DIVU 0xFFFFFFFF / 1: relies on the dropped-hi-MSB take path
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0, lat, busy_n, ctl);
        check("divone_hilo", {hi, lo}, {32'h0, 32'hFFFF_FFFF});

        // DIVU by zero: DONE is entered on the accepting edge itself
        run_op(1'b1, 32'h1234, 32'd0, 0, lat, busy_n, ctl);
        check("div0_lat",  64'(lat), 64'd1);
        check("div0_busy", 64'(busy_n), 64'd0);
        check("div0_hilo", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
        check("div0_dz",   64'(div_zero), 64'd1);

        // Following MULTU clears div_zero
        run_op(1'b0, 32'd3, 32'd4, 0, lat, busy_n, ctl);
        check("clr_dz",   64'(div_zero), 64'd0);
        check("clr_hilo", {hi, lo}, 64'd12);

        // start re-pulsed in CALC cycle 5 with a different op/operands
        run_op(1'b0, 32'd6, 32'd7, 5, lat, busy_n, ctl);
        check("repulse_lat",  64'(lat), 64'd33);
        check("repulse_busy", 64'(busy_n), 64'd32);
        check("repulse_hilo", {hi, lo}, 64'h2A);
        @(negedge clk);
        @(negedge clk);
        check("repulse_noq", 64'(busy), 64'd0);

        // Reset in CALC cycle 10 aborts immediately
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_pre", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_alu",  {alu_a, alu_b}, 64'd0);
        check("abort_ctrl", {61'd0, alu_ctrl, alu_bin}, 64'd0);
        begin
            int seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) seen++;
            end
            rst_n = 1'b1;
            repeat (40) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("abort_nodone", 64'(seen), 64'd0);
        end

        // Fresh operation after reset release
        run_op(1'b1, 32'd100, 32'd7, 0, lat, busy_n, ctl);
        check("post_lat",  64'(lat), 64'd33);
        check("post_hilo", {hi, lo}, {32'd2, 32'd14});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
